// File: rtl/apb_crc_engine.sv
// APB-attached bit-serial CRC engine: one data byte is shifted MSB-first over eight cycles,
// while DATA, RESULT and CTRL accesses wait and STATUS stays readable.
module apb_crc_engine #(
    parameter int unsigned       CRC_W   = 8,
    parameter logic [CRC_W-1:0]  POLY    = CRC_W'('h07),
    parameter logic [CRC_W-1:0]  INIT    = '0,
    parameter logic [CRC_W-1:0]  XOR_OUT = '0
) (
    input  logic        p_clk_i,
    input  logic        p_rst_i,
    input  logic        p_sel_i,
    input  logic        p_enable_i,
    input  logic        p_we_i,
    input  logic [31:0] p_adr_i,
    input  logic [31:0] p_dat_i,
    output logic [31:0] p_dat_o,
    output logic        p_ready
);

    typedef enum logic {StIdle, StShift} state_e;

    localparam logic [1:0] AdrData   = 2'd0;
    localparam logic [1:0] AdrResult = 2'd1;
    localparam logic [1:0] AdrCtrl   = 2'd2;
    localparam logic [1:0] AdrStatus = 2'd3;

    state_e           state_q;
    logic             busy_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic [15:0]      count_q;

    logic [1:0] reg_idx;
    logic       xfer;
    logic       data_wr;
    logic       ctrl_init;
    logic       fb;
    logic       unused_bits;

    assign reg_idx     = p_adr_i[3:2];
    assign unused_bits = ^{p_adr_i[31:4], p_adr_i[1:0], p_dat_i[31:8]};

    // STATUS never waits so software can poll busy while a byte is in flight.
    assign p_ready   = !(busy_q && p_sel_i && (reg_idx != AdrStatus));
    assign xfer      = p_sel_i && p_enable_i && p_ready;
    assign data_wr   = xfer && p_we_i && (reg_idx == AdrData);
    assign ctrl_init = xfer && p_we_i && (reg_idx == AdrCtrl) && p_dat_i[0];

    always_comb begin
        fb    = crc_q[CRC_W-1] ^ shift_q[7];
        crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            crc_q     <= INIT;
            count_q   <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (data_wr) begin
                        shift_q   <= p_dat_i[7:0];
                        bit_cnt_q <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= StShift;
                    end else if (ctrl_init) begin
                        crc_q   <= INIT;
                        count_q <= 16'd0;
                    end
                end
                StShift: begin
                    crc_q     <= crc_d;
                    shift_q   <= {shift_q[6:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        count_q <= count_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        p_dat_o = '0;
        if (p_sel_i && !p_we_i) begin
            unique case (reg_idx)
                AdrResult: p_dat_o = 32'(crc_q ^ XOR_OUT);
                AdrStatus: p_dat_o = {count_q, 15'd0, busy_q};
                default:   p_dat_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_crc_engine.sv
// Directed plus randomized bench for apb_crc_engine; an 8-bit default instance and a
// 16-bit (poly 0x1021) instance share one APB bus and are checked against a bytewise model.
module tb_apb_crc_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        en;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat8;
    logic [31:0] rdat16;
    logic        rdy8;
    logic        rdy16;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m8;
    logic [31:0] m16;
    logic [15:0] mcnt;

    always #5 clk = ~clk;

    apb_crc_engine dut8 (
        .p_clk_i    (clk),
        .p_rst_i    (rst),
        .p_sel_i    (sel),
        .p_enable_i (en),
        .p_we_i     (we),
        .p_adr_i    (adr),
        .p_dat_i    (wdat),
        .p_dat_o    (rdat8),
        .p_ready    (rdy8)
    );

    apb_crc_engine #(
        .CRC_W   (16),
        .POLY    (16'h1021),
        .INIT    (16'h0000),
        .XOR_OUT (16'h0000)
    ) dut16 (
        .p_clk_i    (clk),
        .p_rst_i    (rst),
        .p_sel_i    (sel),
        .p_enable_i (en),
        .p_we_i     (we),
        .p_adr_i    (adr),
        .p_dat_i    (wdat),
        .p_dat_o    (rdat16),
        .p_ready    (rdy16)
    );

    // Textbook bytewise CRC: fold the byte into the top, then eight polynomial divisions.
    function automatic logic [31:0] crc_step(input int w, input logic [31:0] poly,
                                             input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] crc;
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        crc  = crc_in ^ (32'(b) << (w - 8));
        for (int i = 0; i < 8; i++) begin
            if (crc[w-1]) crc = ((crc << 1) ^ poly) & mask;
            else          crc = (crc << 1) & mask;
        end
        return crc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        m8   = 32'h0;
        m16  = 32'h0;
        mcnt = 16'h0;
    endtask

    // One access; hold keeps sel/enable high so the next access starts with no setup phase.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit setup, input bit hold,
                        output logic [31:0] r8, output logic [31:0] r16, output int waits);
        waits = 0;
        sel   = 1'b1;
        we    = w;
        adr   = a;
        wdat  = d;
        if (setup) begin
            en = 1'b0;
            tick();
        end
        en = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy8) break;
            waits++;
            if (waits > 40) begin
                vectors++;
                miscompares++;
                $error("FAIL access_timeout: observed ready 0 after %0d cycles expected 1", waits);
                break;
            end
            tick();
        end
        r8  = rdat8;
        r16 = rdat16;
        tick();
        if (!hold) begin
            sel = 1'b0;
            en  = 1'b0;
            we  = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit setup, input bit hold,
                              output int waits);
        logic [31:0] r8;
        logic [31:0] r16;
        logic [31:0] junk;
        junk = $urandom();
        xfer(1'b1, 32'h0, {junk[31:8], b}, setup, hold, r8, r16, waits);
        m8  = crc_step(8, 32'h07, m8, b);
        m16 = crc_step(16, 32'h1021, m16, b);
        mcnt++;
    endtask

    task automatic write_ctrl(input logic [31:0] d, output int waits);
        logic [31:0] r8;
        logic [31:0] r16;
        xfer(1'b1, 32'h8, d, 1'b1, 1'b0, r8, r16, waits);
        if (d[0]) model_init();
    endtask

    task automatic wait_idle();
        logic [31:0] r8;
        logic [31:0] r16;
        int          waits;
        for (int i = 0; i < 20; i++) begin
            xfer(1'b0, 32'hC, 32'h0, 1'b1, 1'b0, r8, r16, waits);
            if (!r8[0]) return;
        end
        vectors++;
        miscompares++;
        $error("FAIL idle_timeout: observed busy 1 expected 0");
    endtask

    task automatic check_result(input string tag);
        logic [31:0] r8;
        logic [31:0] r16;
        int          waits;
        xfer(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check({tag, "_r8"}, r8, m8);
        check({tag, "_r16"}, r16, m16);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] r8;
        logic [31:0] r16;
        int          waits;
        wait_idle();
        xfer(1'b0, 32'hC, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check(tag, r8, {mcnt, 16'h0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r8;
        logic [31:0] r16;
        logic [31:0] rnd;
        logic [7:0]  msg [9];
        int          waits;
        int          op;

        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst = 1'b1; sel = 1'b0; en = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0;
        model_init();

        tick();
        tick();
        @(negedge clk);
        check("rst_ready", 32'(rdy8), 32'h1);
        check("rst_dat", rdat8, 32'h0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_ready", 32'(rdy8), 32'h1);
        check("post_rst_dat", rdat8, 32'h0);
        tick();

        // Single byte 0xAA from INIT=0.
        write_byte(8'hAA, 1'b1, 1'b0, waits);
        check("idle_zero_wait", 32'(waits), 32'h0);
        wait_idle();
        xfer(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("result_aa", r8, 32'h0000005F);
        xfer(1'b0, 32'hC, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("status_aa", r8, 32'h00010000);

        write_byte(8'h33, 1'b1, 1'b0, waits);
        xfer(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("result_aa33", r8, 32'h00000003);
        check_status("status_aa33");
        check("status_aa33_const", {16'h0, mcnt}, 32'h2);

        // CTRL bit0=0 is a no-op; bit0=1 re-initialises.
        write_ctrl(32'hFFFF_FFFE, waits);
        check_result("ctrl_noop");
        check_status("ctrl_noop_status");
        write_ctrl(32'h0000_0001, waits);
        xfer(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("ctrl_init_result", r8, 32'h0);
        xfer(1'b0, 32'hC, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("ctrl_init_status", r8, 32'h0);

        // "123456789" back-to-back: every write after the first sits through all 8 shifts.
        for (int i = 0; i < 9; i++) begin
            write_byte(msg[i], (i == 0), (i != 8), waits);
            check($sformatf("b2b_waits_%0d", i), 32'(waits), (i == 0) ? 32'd0 : 32'd8);
        end
        xfer(1'b0, 32'h4, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("check_crc8", r8, 32'h000000F4);
        check("check_crc16", r16, 32'h000031C3);
        check_status("check_status");

        // CTRL during SHIFT: setup takes one shift cycle, the remaining seven stall.
        write_ctrl(32'h1, waits);
        write_byte(8'hAA, 1'b1, 1'b0, waits);
        write_ctrl(32'h1, waits);
        check("ctrl_stall_waits", 32'(waits), 32'd7);
        xfer(1'b0, 32'hC, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("ctrl_stall_status", r8, 32'h0);
        check_result("ctrl_stall_result");

        // Reset while the bit counter reads 4.
        write_byte(8'hAA, 1'b1, 1'b0, waits);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(rdy8), 32'h1);
        check("rst_mid_dat", rdat8, 32'h0);
        tick();
        rst = 1'b0;
        model_init();
        xfer(1'b0, 32'hC, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("rst_mid_status", r8, 32'h0);
        check("rst_mid_status_wait", 32'(waits), 32'h0);
        check_result("rst_mid_result");
        xfer(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, r8, r16, waits);
        check("unmapped_dat", r8, 32'h0);
        check("unmapped_wait", 32'(waits), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            op  = $urandom_range(0, 9);
            rnd = $urandom();
            if (op <= 4) begin
                write_byte(rnd[7:0], 1'b1, 1'b0, waits);
            end else if (op == 5) begin
                check_result("rand_result");
            end else if (op == 6) begin
                check_status("rand_status");
            end else if (op == 7) begin
                write_ctrl({rnd[31:1], (rnd[3:0] == 4'h0)}, waits);
            end else if (op == 8) begin
                xfer(1'b1, {rnd[31:4], rnd[4] ? 2'd1 : 2'd3, 2'b00}, $urandom(), 1'b1, 1'b0,
                     r8, r16, waits);
            end else begin
                xfer(1'b0, {rnd[31:4], rnd[4] ? 2'd0 : 2'd2, 2'b00}, 32'h0, 1'b1, 1'b0,
                     r8, r16, waits);
                check("rand_wo_read", r8, 32'h0);
            end
        end
        check_result("final_result");
        check_status("final_status");
        @(negedge clk);
        check("idle_bus_dat", rdat8, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
